// File: rtl/psk_transmitter.sv
// rtl/psk_transmitter.sv - framed BPSK transmitter on a 12-bit NCO square-wave carrier (PSK_TX_DIFF_EN selects differential encoding)
module psk_transmitter #(
  parameter logic [11:0] FCW           = 12'h100,
  parameter int          SYM_LEN       = 256,
  parameter int          PREAMBLE_SYMS = 8,
  parameter int          GAP_SYMS      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       sym_stb,
  output logic       carrier,
  output logic       sig
);

  localparam int              SCW      = $clog2(SYM_LEN);
  localparam logic [SCW-1:0]  SYM_LAST = SCW'(SYM_LEN - 1);
  localparam logic [15:0]     PRE_LAST = 16'(PREAMBLE_SYMS - 1);
  // GAP_LAST is never reached when GAP_SYMS is 0 because GAP is skipped entirely.
  localparam logic [15:0]     GAP_LAST = 16'(GAP_SYMS - 1);
  localparam logic [15:0]     DAT_LAST = 16'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_DATA,
    S_GAP
  } state_t;

  state_t         state;
  state_t         nxt_state;
  logic [11:0]    acc;
  logic [7:0]     shreg;
  logic [SCW-1:0] sym_cnt;
  logic [15:0]    bit_cnt;
  logic           mod;
  logic           sym_end;
  logic           nxt_bit;
  logic           start_bit;
  logic           mod_start;
  logic           accept;

  assign accept  = valid && ready;

  // Both outputs are pure functions of registers, so no input reaches them combinationally.
  assign carrier = acc[11];
  assign sig     = acc[11] ^ mod;

  // Free-running phase accumulator; frames never touch it so carrier phase stays continuous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 12'd0;
    end else begin
      acc <= acc + FCW;
    end
  end

  // Decide which state and bit the next symbol carries when the current symbol ends.
  always_comb begin
    sym_end   = (sym_cnt == SYM_LAST);
    nxt_state = state;
    nxt_bit   = 1'b0;
    case (state)
      S_PRE: begin
        if (bit_cnt == PRE_LAST) begin
          nxt_state = S_SYNC;
          nxt_bit   = 1'b1;
        end
      end
      S_SYNC: begin
        nxt_state = S_DATA;
        nxt_bit   = shreg[0];
      end
      S_DATA: begin
        if (bit_cnt == DAT_LAST) begin
          nxt_state = (GAP_SYMS == 0) ? S_IDLE : S_GAP;
        end else begin
          // shreg shifts on this same edge, so the upcoming bit is shreg[1] now.
          nxt_bit = shreg[1];
        end
      end
      S_GAP: begin
        if (bit_cnt == GAP_LAST) begin
          nxt_state = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  // Phase flag for a symbol being started: the preamble starts with bit 0 on accept.
  always_comb begin
    start_bit = (state == S_IDLE) ? 1'b0 : nxt_bit;
`ifdef PSK_TX_DIFF_EN
    mod_start = mod ^ start_bit;
`else
    mod_start = start_bit;
`endif
  end

  // Frame sequencer with registered handshake, strobe and phase flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= 8'd0;
      sym_cnt <= '0;
      bit_cnt <= 16'd0;
      mod     <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      sym_stb <= 1'b0;
    end else begin
      sym_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg   <= data;
            sym_cnt <= '0;
            bit_cnt <= 16'd0;
            state   <= S_PRE;
            ready   <= 1'b0;
            busy    <= 1'b1;
            sym_stb <= 1'b1;
            mod     <= mod_start;
          end
        end
        default: begin
          if (sym_end) begin
            sym_cnt <= '0;
            if (state == S_DATA) begin
              shreg <= {1'b0, shreg[7:1]};
            end
            if (nxt_state == S_IDLE) begin
              state <= S_IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
`ifndef PSK_TX_DIFF_EN
              // Absolute mode parks the flag so an idle sig is the bare carrier.
              mod   <= 1'b0;
`endif
            end else begin
              state   <= nxt_state;
              sym_stb <= 1'b1;
              mod     <= mod_start;
              bit_cnt <= (nxt_state == state) ? bit_cnt + 16'd1 : 16'd0;
            end
          end else begin
            sym_cnt <= sym_cnt + SCW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psk_transmitter.sv
// tb/tb_psk_transmitter.sv - directed table-driven bench for psk_transmitter at default and shortened framing
module tb_psk_transmitter;

  logic       clk = 1'b0;
  logic       d_rst_n = 1'b0;
  logic [7:0] d_data = 8'd0;
  logic       d_valid = 1'b0;
  logic       d_ready, d_busy, d_stb, d_carrier, d_sig;
  logic       s_rst_n = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_ready, s_busy, s_stb, s_carrier, s_sig;

  int n_pass = 0;
  int n_total = 0;
  int carr_err = 0;
  logic [11:0] m_acc_d, m_acc_s;

  always #5 clk = ~clk;

  psk_transmitter u_def (
    .clk(clk), .rst_n(d_rst_n), .data(d_data), .valid(d_valid), .ready(d_ready),
    .busy(d_busy), .sym_stb(d_stb), .carrier(d_carrier), .sig(d_sig)
  );

  psk_transmitter #(.FCW(12'h100), .SYM_LEN(4), .PREAMBLE_SYMS(1), .GAP_SYMS(0)) u_small (
    .clk(clk), .rst_n(s_rst_n), .data(s_data), .valid(s_valid), .ready(s_ready),
    .busy(s_busy), .sym_stb(s_stb), .carrier(s_carrier), .sig(s_sig)
  );

  // Reference phase accumulators: count FCW per clock from reset, never touched by frames.
  always @(posedge clk or negedge d_rst_n) begin
    if (!d_rst_n) m_acc_d <= 12'd0;
    else          m_acc_d <= m_acc_d + 12'h100;
  end
  always @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) m_acc_s <= 12'd0;
    else          m_acc_s <= m_acc_s + 12'h100;
  end
  always @(negedge clk) begin
    if (d_carrier !== m_acc_d[11] || s_carrier !== m_acc_s[11]) carr_err++;
  end

  typedef struct {
    int          inst;
    logic [7:0]  data;
    bit          poke;
    int          nsym;
    logic [18:0] bits;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic logic get_x(input int inst);
    return (inst == 0) ? (d_sig ^ d_carrier) : (s_sig ^ s_carrier);
  endfunction
  function automatic logic get_ready(input int inst);
    return (inst == 0) ? d_ready : s_ready;
  endfunction
  function automatic logic get_busy(input int inst);
    return (inst == 0) ? d_busy : s_busy;
  endfunction
  function automatic logic get_stb(input int inst);
    return (inst == 0) ? d_stb : s_stb;
  endfunction

  task automatic set_in(input int inst, input logic v, input logic [7:0] d);
    if (inst == 0) begin d_valid = v; d_data = d; end
    else begin s_valid = v; s_data = d; end
  endtask

  task automatic wait_ready(input int inst, input int limit);
    int t = 0;
    while (!get_ready(inst) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", get_ready(inst), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int          len;
    int          stb_n;
    bit          early;
    logic        x_prev;
    logic        m;
    logic [18:0] got;
    logic [18:0] expx;
    len   = (v.inst == 0) ? 256 : 4;
    stb_n = 0;
    early = 0;
    got   = '0;
    expx  = '0;
    wait_ready(v.inst, 300);
    x_prev = get_x(v.inst);
`ifndef PSK_TX_DIFF_EN
    check("idle_sig_eq_carrier", x_prev, 0);
`endif
    set_in(v.inst, 1'b1, v.data);
    @(posedge clk);
    for (int c = 0; c < v.nsym * len; c++) begin
      @(negedge clk);
      // data flips right after accept; optional valid pulses while busy must be ignored
      set_in(v.inst, v.poke && c > 0 && c < v.nsym * len - 2 && (c % 3 == 1), ~v.data);
      if (c == 0) check("busy_stb_on_accept", {get_busy(v.inst), get_stb(v.inst)}, 2'b11);
      if (get_stb(v.inst)) stb_n++;
      if (get_ready(v.inst)) early = 1;
      if (c % len == len / 2) got[c / len] = get_x(v.inst);
    end
    @(negedge clk);
    check("ready_at_frame_end", {get_ready(v.inst), get_busy(v.inst), get_stb(v.inst)}, 3'b100);
    check("ready_early", early, 0);
    check("sym_stb_count", stb_n, v.nsym);
    m = x_prev;
    for (int k = 0; k < v.nsym; k++) begin
`ifdef PSK_TX_DIFF_EN
      m = m ^ v.bits[k];
`else
      m = v.bits[k];
`endif
      expx[k] = m;
    end
    check("symbol_phases", got, expx);
`ifdef PSK_TX_DIFF_EN
    check("idle_mod_hold", get_x(v.inst), m);
`else
    check("idle_mod_zero", get_x(v.inst), 0);
`endif
  endtask

  initial begin
    int first_ready;
    int second_acc;
    int n;
    int bad;

    // symbol bits, symbol 0 in bit 0: preamble zeros, sync 1, data LSB first, gap zeros
    vecs[0] = '{0, 8'h01, 1'b1, 19, 19'b00_00000001_1_00000000};
    vecs[1] = '{0, 8'hA5, 1'b0, 19, 19'b00_10100101_1_00000000};
    vecs[2] = '{1, 8'hFF, 1'b0, 10, 19'b000000000_11111111_1_0};
    vecs[3] = '{1, 8'hA5, 1'b1, 10, 19'b000000000_10100101_1_0};
    vecs[4] = '{1, 8'h00, 1'b0, 10, 19'b000000000_00000000_1_0};
    vecs[5] = '{1, 8'h3C, 1'b1, 10, 19'b000000000_00111100_1_0};
    vecs[6] = '{1, 8'h80, 1'b0, 10, 19'b000000000_10000000_1_0};

    repeat (3) @(negedge clk);
    check("reset_def", {d_ready, d_busy, d_stb, d_carrier, d_sig}, 5'b10000);
    check("reset_small", {s_ready, s_busy, s_stb, s_carrier, s_sig}, 5'b10000);
    d_rst_n = 1'b1;
    s_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back with valid held: accept exactly one cycle after ready rises.
    wait_ready(1, 50);
    set_in(1, 1'b1, 8'h5A);
    @(posedge clk);
    first_ready = -1;
    second_acc = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 1) s_data = 8'h33;
      if (first_ready >= 0 && s_stb) begin
        second_acc = c;
        break;
      end
      if (s_ready && first_ready < 0) first_ready = c;
    end
    s_valid = 1'b0;
    check("b2b_ready_rise", first_ready, 40);
    check("b2b_second_accept", second_acc, 41);
    wait_ready(1, 100);

    // Reset mid-DATA on the default instance, then carrier restarts from phase 0.
    wait_ready(0, 50);
    set_in(0, 1'b1, 8'hC3);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 8'hC3);
    repeat ((8 + 1 + 2) * 256 + 10) @(negedge clk);
    check("busy_mid_data", d_busy, 1);
    d_rst_n = 1'b0;
    #1;
    check("reset_mid_frame", {d_ready, d_busy, d_stb, d_carrier, d_sig}, 5'b10000);
    @(negedge clk);
    @(negedge clk);
    d_rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (d_carrier) break;
    end
    check("carrier_rise_after_release", n, 8);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (d_stb || !d_ready || d_busy) bad++;
    end
    check("no_partial_symbol", bad, 0);

    check("carrier_phase_continuous", carr_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
